// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
//   master : producer of operands / consumer of results (the datapath driving the multiplier)
//   slave  : the multiplier itself
// Signals:
//   in_valid, in_ready, in_a, in_b           operand channel
//   out_valid, out_ready, out_p              result channel
//   out_overflow, out_underflow              result flags, qualified by out_valid
interface fp_mult_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic         out_overflow;
  logic         out_underflow;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, out_overflow, out_underflow
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, out_overflow, out_underflow
  );
endinterface

// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier {sign,exp,man} with round-to-nearest-even,
// saturation on overflow/Inf/NaN and flush-to-zero on underflow/denormals.
// Operands accepted at edge N are presented on out_p after edge N+3; one
// product per clock when the consumer keeps out_ready high.
// Ports:
//   clk    in  clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of fp_mult_pipe_if (operand and result handshakes)
// Pipeline:
//   s1  field decode, hidden bit, zero/special detect
//   s2  mantissa product, biased exponent sum
//   s3  normalise and round
//   out result select (zero / saturate / flush / normal) into output register
module fp_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input logic          clk,
  input logic          rst_n,
  fp_mult_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;       // mantissa with hidden bit
  localparam int PW = 2 * MAN_W + 2;   // full product width
  localparam int EW = EXP_W + 2;       // signed exponent headroom

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  // Handshake: the whole pipe freezes while the output is blocked.
  logic stall;
  logic adv;
  logic out_valid_q;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = ~stall;

  // ---------------- stage 1: decode ----------------
  logic [EXP_W-1:0] ea_c, eb_c;
  logic [MW-1:0]    ma_c, mb_c;

  assign ea_c = bus.in_a[W-2 -: EXP_W];
  assign eb_c = bus.in_b[W-2 -: EXP_W];
  assign ma_c = {|ea_c, bus.in_a[MAN_W-1:0]};
  assign mb_c = {|eb_c, bus.in_b[MAN_W-1:0]};

  logic             s1_valid;
  logic             s1_sign, s1_zero, s1_spec;
  logic [EXP_W-1:0] s1_ea, s1_eb;
  logic [MW-1:0]    s1_ma, s1_mb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_spec  <= 1'b0;
      s1_ea    <= '0;
      s1_eb    <= '0;
      s1_ma    <= '0;
      s1_mb    <= '0;
    end else if (adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= bus.in_a[W-1] ^ bus.in_b[W-1];
        s1_zero <= (ea_c == '0) | (eb_c == '0);
        s1_spec <= (&ea_c) | (&eb_c);
        s1_ea   <= ea_c;
        s1_eb   <= eb_c;
        s1_ma   <= ma_c;
        s1_mb   <= mb_c;
      end
    end
  end

  // ---------------- stage 2: multiply ----------------
  logic [PW-1:0]        prod_c;
  logic signed [EW-1:0] exp_sum_c;

  assign prod_c    = PW'(s1_ma) * PW'(s1_mb);
  assign exp_sum_c = $signed({2'b00, s1_ea}) + $signed({2'b00, s1_eb}) - BIAS_S;

  logic                 s2_valid;
  logic                 s2_sign, s2_zero, s2_spec;
  logic [PW-1:0]        s2_prod;
  logic signed [EW-1:0] s2_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_spec  <= 1'b0;
      s2_prod  <= '0;
      s2_exp   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_spec <= s1_spec;
        s2_prod <= prod_c;
        s2_exp  <= exp_sum_c;
      end
    end
  end

  // ---------------- stage 3: normalise + round ----------------
  // The product of two [1,2) mantissas lies in [1,4); the MSB tells which.
  logic                 norm_c;
  logic [MAN_W-1:0]     man_pre_c;
  logic                 guard_c, sticky_c, rnd_c, carry_c;
  logic [MAN_W:0]       man_sum_c;
  logic [1:0]           e_inc_c;
  logic signed [EW-1:0] e_f_c;

  assign norm_c    = s2_prod[PW-1];
  assign man_pre_c = norm_c ? s2_prod[PW-2 -: MAN_W] : s2_prod[PW-3 -: MAN_W];
  assign guard_c   = norm_c ? s2_prod[PW-2-MAN_W] : s2_prod[PW-3-MAN_W];
  assign sticky_c  = norm_c ? |s2_prod[PW-3-MAN_W:0] : |s2_prod[PW-4-MAN_W:0];
  assign rnd_c     = guard_c & (sticky_c | man_pre_c[0]);
  assign man_sum_c = {1'b0, man_pre_c} + {{MAN_W{1'b0}}, rnd_c};
  // On carry-out the low bits are already zero, i.e. mantissa 1.000 at exp+1.
  assign carry_c   = man_sum_c[MAN_W];
  assign e_inc_c   = {1'b0, norm_c} + {1'b0, carry_c};
  assign e_f_c     = s2_exp + $signed({{(EW-2){1'b0}}, e_inc_c});

  logic                 s3_valid;
  logic                 s3_sign, s3_zero, s3_spec;
  logic [MAN_W-1:0]     s3_man;
  logic signed [EW-1:0] s3_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_sign  <= 1'b0;
      s3_zero  <= 1'b0;
      s3_spec  <= 1'b0;
      s3_man   <= '0;
      s3_exp   <= '0;
    end else if (adv) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_sign <= s2_sign;
        s3_zero <= s2_zero;
        s3_spec <= s2_spec;
        s3_man  <= man_sum_c[MAN_W-1:0];
        s3_exp  <= e_f_c;
      end
    end
  end

  // ---------------- output select ----------------
  // Zero wins only over finite operands; any Inf/NaN operand saturates.
  logic [W-1:0] p_c;
  logic         ovf_c, unf_c;

  always_comb begin
    p_c   = '0;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    if (s3_zero && !s3_spec) begin
      p_c = {s3_sign, {(W-1){1'b0}}};
    end else if (s3_spec || (s3_exp >= E_MAX)) begin
      p_c   = {s3_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      ovf_c = 1'b1;
    end else if (s3_exp <= E_ZERO) begin
      p_c   = {s3_sign, {(W-1){1'b0}}};
      unf_c = 1'b1;
    end else begin
      p_c = {s3_sign, s3_exp[EXP_W-1:0], s3_man};
    end
  end

  logic [W-1:0] out_p_q;
  logic         out_ovf_q, out_unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s3_valid;
      if (s3_valid) begin
        out_p_q   <= p_c;
        out_ovf_q <= ovf_c;
        out_unf_q <= unf_c;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_p         = out_p_q;
  assign bus.out_overflow  = out_ovf_q;
  assign bus.out_underflow = out_unf_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe (half precision: EXP_W=5, MAN_W=10).
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_mult_pipe_if #(.EXP_W(5), .MAN_W(10)) bus ();

  fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [17:0] res;     // {overflow, underflow, p}
    int          acc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   stall_seen = 0;
  bit   lat_flag = 0;
  bit   use_dir  = 0;
  logic [17:0] dir_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
  endfunction

  // Reference: exact integer product, then round-to-nearest-even by remainder.
  function automatic logic [17:0] ref_mul(logic [15:0] a, logic [15:0] b);
    int ea, eb, p, e, sh, q, rem, half;
    logic s;
    logic [17:0] r;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    s  = a[15] ^ b[15];
    if ((ea == 0 || eb == 0) && !(ea == 31 || eb == 31)) return {2'b00, s, 15'h0000};
    if (ea == 31 || eb == 31) return {2'b10, s, 5'h1e, 10'h3ff};
    p = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
    e = ea + eb - 15;
    if (p >= (1 << 21)) begin sh = 11; e = e + 1; end
    else sh = 10;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    if (q == 2048) begin q = 1024; e = e + 1; end
    if (e >= 31) return {2'b10, s, 5'h1e, 10'h3ff};
    if (e <= 0)  return {2'b01, s, 15'h0000};
    r = {2'b00, s, e[4:0], q[9:0]};
    return r;
  endfunction

  // Monitor: pushes on input transfer, pops/compares on output transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        e.res     = use_dir ? dir_exp : ref_mul(bus.in_a, bus.in_b);
        e.acc     = cyc + 1;
        e.chk_lat = lat_flag;
        sb.push_back(e);
      end
      if (bus.out_valid && !bus.out_ready) stall_seen++;
      chk(bus.in_ready == !(bus.out_valid && !bus.out_ready), "in_ready",
          32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_out", 32'(bus.out_p), 32'h0);
        end else begin
          exp_t e;
          logic [17:0] act;
          e   = sb.pop_front();
          act = {bus.out_overflow, bus.out_underflow, bus.out_p};
          chk(act === e.res, "result", 32'(act), 32'(e.res));
          if (e.chk_lat) chk((cyc - e.acc) == 3, "latency", 32'(cyc - e.acc), 32'd3);
        end
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input bit dir, input logic [17:0] dexp);
    int n;
    use_dir     = dir;
    dir_exp     = dexp;
    bus.in_a    = a;
    bus.in_b    = b;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(1'b0, "send_timeout", 32'(n), 32'd200);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    use_dir      = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(sb.size() == 0, "drain", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 1) == 1) v[14:10] = 5'($urandom_range(8, 22));
    return v;
  endfunction

  typedef struct { logic [15:0] a; logic [15:0] b; logic [17:0] r; } dir_t;
  dir_t dirs[$];
  bit   rnd_done;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(!bus.out_valid && bus.out_p == 0 && !bus.out_overflow && !bus.out_underflow,
        "reset_state", {bus.out_valid, bus.out_overflow, bus.out_underflow, 13'h0, bus.out_p}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk(bus.in_ready == 1'b1, "in_ready_after_reset", 32'(bus.in_ready), 32'd1);

    // Single op with latency check.
    lat_flag = 1;
    send(16'h3c00, 16'h3c00, 1, {2'b00, 16'h3c00});
    lat_flag = 0;
    drain();

    // Directed cases, back-to-back.
    dirs.push_back('{16'h3e00, 16'h3e00, {2'b00, 16'h4080}});
    dirs.push_back('{16'hc000, 16'h3c00, {2'b00, 16'hc000}});
    dirs.push_back('{16'h3c01, 16'h3e00, {2'b00, 16'h3e02}});
    dirs.push_back('{16'h3bff, 16'h3c01, {2'b00, 16'h3c00}});
    dirs.push_back('{16'h7800, 16'h4000, {2'b10, 16'h7bff}});
    dirs.push_back('{16'h7c00, 16'h3c00, {2'b10, 16'h7bff}});
    dirs.push_back('{16'h0400, 16'h0400, {2'b01, 16'h0000}});
    dirs.push_back('{16'h0000, 16'h7bff, {2'b00, 16'h0000}});
    dirs.push_back('{16'h0000, 16'h7c00, {2'b10, 16'h7bff}});
    dirs.push_back('{16'hbc00, 16'hbc00, {2'b00, 16'h3c00}});
    foreach (dirs[i]) send(dirs[i].a, dirs[i].b, 1, dirs[i].r);
    drain();

    // 8 back-to-back with a 4-cycle output stall mid-stream.
    stall_seen = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), 0, '0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    chk(stall_seen >= 4, "stall_seen", 32'(stall_seen), 32'd4);

    // Random stream with random backpressure.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) send(rand_op(), rand_op(), 0, '0);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset with ops in flight.
    for (int i = 0; i < 4; i++) send(rand_op(), rand_op(), 0, '0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk(!bus.out_valid && bus.out_p == 0 && !bus.out_overflow && !bus.out_underflow,
        "reset_inflight", {bus.out_valid, bus.out_overflow, bus.out_underflow, 13'h0, bus.out_p}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk(!bus.out_valid, "no_stale_out", 32'(bus.out_valid), 32'd0);
    chk(bus.in_ready == 1'b1, "in_ready_post_reset", 32'(bus.in_ready), 32'd1);
    lat_flag = 1;
    send(16'h3e00, 16'h3e00, 1, {2'b00, 16'h4080});
    lat_flag = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
